instruction_loader: RTL

- Boot-time writer for the processor's instruction memory; the write-side counterpart of the fetch path, which only reads instruction memory.
- Accepts a byte stream (valid/ready), assembles little-endian 32-bit instructions and writes them to consecutive word addresses.
- Holds the processor in reset until a complete image has been loaded and its checksum verified.
- Sits between the host byte link (UART receiver or testbench) and the instruction memory write port.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/byte_assembler.sv | 37 +++
 rtl/instruction_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    COUNT = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam int WORD_BYTES  = 4;
  localparam int COUNT_BYTES = 4;
  localparam int BYTE_IDX_W  = $clog2((COUNT_BYTES > WORD_BYTES) ? COUNT_BYTES : WORD_BYTES);

  // Byte address of word `idx` relative to `base`, wrapping modulo 2^64.
  function automatic logic [63:0] word_addr(input logic [63:0] base, input logic [31:0] idx);
    return base + {30'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects bytes into a little-endian 32-bit word; shared by the count field and data words.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [BYTE_IDX_W-1:0] idx_r;
  logic [31:0]           shreg_r;

  // Word as it will look once the current byte is shifted in at the top.
  always_comb begin
    word          = {data, shreg_r[31:8]};
    word_complete = take && (idx_r == BYTE_IDX_W'(WORD_BYTES - 1));
  end

  // Byte index and shift register update.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      idx_r   <= '0;
      shreg_r <= 32'd0;
    end else if (take) begin
      idx_r   <= idx_r + BYTE_IDX_W'(1);
      shreg_r <= word;
    end else begin
      idx_r   <= idx_r;
      shreg_r <= shreg_r;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: parses count/words/checksum from a byte stream, writes instruction memory
// and releases the processor only after a verified image.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int          IMEM_DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR        = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] words_loaded
);

  state_t      state_r;
  logic [31:0] n_words_r;
  logic [31:0] word_index_r;
  logic [7:0]  xor_r;
  logic        accept_s;
  logic        take_s;
  logic        restart_s;
  logic [31:0] asm_word_s;
  logic        word_complete_s;

  // in_ready is a pure state decode, forced low while reset is asserted.
  always_comb begin
    case (state_r)
      COUNT, DATA, CHECK: in_ready = reset;
      default:            in_ready = 1'b0;
    endcase
    accept_s  = in_valid && in_ready;
    take_s    = accept_s && ((state_r == COUNT) || (state_r == DATA));
    restart_s = start && ((state_r == DONE) || (state_r == ERROR));
  end

  assign words_loaded = word_index_r;

  byte_assembler u_asm (
    .clock         (clock),
    .reset         (reset),
    .clear         (restart_s),
    .take          (take_s),
    .data          (in_data),
    .word          (asm_word_s),
    .word_complete (word_complete_s)
  );

  // Load sequencer with registered memory-port and status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= COUNT;
      n_words_r    <= 32'd0;
      word_index_r <= 32'd0;
      xor_r        <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state_r)
        COUNT: begin
          if (word_complete_s) begin
            n_words_r <= asm_word_s;
            if (asm_word_s > 32'(IMEM_DEPTH_WORDS)) begin
              state_r <= ERROR;
              error   <= 1'b1;
            end else if (asm_word_s == 32'd0) begin
              state_r <= CHECK;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            xor_r <= xor_r ^ in_data;
            if (word_complete_s) begin
              imem_we    <= 1'b1;
              imem_wdata <= asm_word_s;
              imem_addr  <= word_addr(BASE_ADDR, word_index_r);
              state_r    <= WRITE;
            end
          end
        end
        WRITE: begin
          imem_we      <= 1'b0;
          word_index_r <= word_index_r + 32'd1;
          state_r      <= ((word_index_r + 32'd1) == n_words_r) ? CHECK : DATA;
        end
        CHECK: begin
          if (accept_s) begin
            if (in_data == xor_r) begin
              state_r  <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state_r <= ERROR;
              error   <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          if (start) begin
            state_r      <= COUNT;
            n_words_r    <= 32'd0;
            word_index_r <= 32'd0;
            xor_r        <= 8'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
          end
        end
        default: begin
          state_r  <= COUNT;
          imem_we  <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule
